// File: rtl/commit_retire_unit.sv
// Commit/retire stage: architectural register file, committed-store buffer and memory drain FSM.
// Defining STORE_FWD_EN adds a combinational store-to-load forwarding lookup (ld_addr/ld_hit/ld_data).

package commit_retire_unit_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } sb_entry_t;
endpackage

module commit_retire_unit
  import commit_retire_unit_pkg::*;
#(
  parameter int unsigned SB_DEPTH     = 8,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_valid,
  input  logic                    commit_store,
  input  logic                    commit_reg_write,
  input  logic [4:0]              commit_dest,
  input  logic [XLEN-1:0]         commit_value,
  input  logic [XLEN-1:0]         commit_Addr,
  input  logic                    commit_exception,
  input  logic                    exc_clear,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    mem_req,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic                    mem_ack,
  output logic                    commit_stall,
  output logic                    sb_empty,
  output logic                    exception_pending,
  output logic                    sb_overflow,
  output logic [RETIRE_CNT_W-1:0] retired_count
`ifdef STORE_FWD_EN
  ,
  input  logic [XLEN-1:0]         ld_addr,
  output logic                    ld_hit,
  output logic [XLEN-1:0]         ld_data
`endif
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REG_N = 32;

  typedef enum logic {IDLE, REQ} state_t;

  logic [XLEN-1:0]  regs [REG_N];
  sb_entry_t        sb_mem [SB_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  state_t           state, state_nx;
  logic             accept, reg_wr, store_cmt, pop, push, load_head;
  sb_entry_t        head_sel;

  // Commit qualification; a full buffer only takes a store when the head leaves this cycle
  always_comb begin
    accept    = commit_valid && !exception_pending;
    reg_wr    = accept && commit_reg_write && !commit_store && (commit_dest != 5'd0);
    store_cmt = accept && commit_store;
    pop       = (state == REQ) && mem_ack;
    push      = store_cmt && ((count != CNT_W'(SB_DEPTH)) || pop);
  end

  assign commit_stall = (count == CNT_W'(SB_DEPTH));
  assign sb_empty     = (count == '0) && (state == IDLE);

  // Read ports with write-first bypass of the same-cycle commit
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0)
      rs1_data = (reg_wr && (commit_dest == rs1_addr)) ? commit_value : regs[rs1_addr];
    if (rs2_addr != 5'd0)
      rs2_data = (reg_wr && (commit_dest == rs2_addr)) ? commit_value : regs[rs2_addr];
  end

  // Drain FSM next state; head stays in the buffer until acknowledged
  always_comb begin
    state_nx  = state;
    load_head = 1'b0;
    head_sel  = sb_mem[rd_ptr];
    case (state)
      IDLE: begin
        if (count != '0) begin
          load_head = 1'b1;
          state_nx  = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (count > CNT_W'(1)) begin
            load_head = 1'b1;
            head_sel  = sb_mem[rd_ptr + PTR_W'(1)];
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      exception_pending <= 1'b0;
      sb_overflow       <= 1'b0;
      retired_count     <= '0;
    end else begin
      state   <= state_nx;
      mem_req <= (state_nx == REQ);
      if (load_head) begin
        mem_addr  <= head_sel.addr;
        mem_wdata <= head_sel.data;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (store_cmt && !push) sb_overflow <= 1'b1;
      // Set wins over clear
      if (commit_exception)  exception_pending <= 1'b1;
      else if (exc_clear)    exception_pending <= 1'b0;
      if (accept) retired_count <= retired_count + RETIRE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (reg_wr) begin
      regs[commit_dest] <= commit_value;
    end
  end

  always_ff @(posedge clk) begin
    if (push) sb_mem[wr_ptr] <= '{addr: commit_Addr, data: commit_value};
  end

`ifdef STORE_FWD_EN
  // Oldest-to-youngest scan so the youngest matching entry wins
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (sb_mem[rd_ptr + PTR_W'(i)].addr == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = sb_mem[rd_ptr + PTR_W'(i)].data;
      end
    end
  end
`endif

endmodule
